// File: rtl/packet_scheduler.sv
// ============================================================================
// packet_scheduler
// Round-robin packet scheduler: locks onto one requester per packet and
// forwards its words through a single registered output stage. The optional
// delivered-packet counter is enabled by defining PKT_SCHED_PKT_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module packet_scheduler #(
    parameter int NUM_SRC       = 2,
    parameter int WIDTH_IN      = 512,
    parameter int ADDRESS_WIDTH = 4,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               s_valid,
    output logic [NUM_SRC-1:0]               s_ready,
    input  logic [NUM_SRC*WIDTH_IN-1:0]      s_data,
    input  logic [NUM_SRC*ADDRESS_WIDTH-1:0] s_dest,
    input  logic [NUM_SRC*LEN_WIDTH-1:0]     s_len,
    input  logic [NUM_SRC*2-1:0]             s_tail_flit,
    output logic [WIDTH_IN-1:0]              o_data_out,
    output logic [ADDRESS_WIDTH-1:0]         o_dest_out,
    output logic                             o_head_out,
    output logic [2:0]                       o_tail_out,
    output logic                             o_valid_out,
`ifdef PKT_SCHED_PKT_COUNT_EN
    output logic [15:0]                      o_pkt_count,
`endif
    input  logic                             o_ready_in
);

    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    logic [GW-1:0]          grant;
    logic [GW-1:0]          rr_ptr;
    logic [LEN_WIDTH-1:0]   count;
    logic [1:0]             tail_flit;
    logic                   first_word;

    logic                     load_en;
    logic                     accept;
    logic                     is_last;
    logic                     sel_valid;
    logic [WIDTH_IN-1:0]      sel_data;
    logic [ADDRESS_WIDTH-1:0] sel_dest;
    logic [LEN_WIDTH-1:0]     sel_len;
    logic [1:0]               sel_tail;
    logic [GW-1:0]            pick;
    logic [GW-1:0]            next_ptr;
    logic                     found;
    int                       idx;

    // Output register may load when it is empty or being drained this cycle.
    assign load_en   = !o_valid_out || o_ready_in;
    assign sel_valid = s_valid[grant];
    assign sel_data  = s_data[int'(grant)*WIDTH_IN +: WIDTH_IN];
    assign sel_dest  = s_dest[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign sel_len   = s_len[int'(grant)*LEN_WIDTH +: LEN_WIDTH];
    assign sel_tail  = s_tail_flit[int'(grant)*2 +: 2];

    assign accept   = (state == BUSY) && sel_valid && load_en;
    assign is_last  = first_word ? (sel_len == '0) : (count == LEN_WIDTH'(1));
    assign s_ready  = (state == BUSY && load_en) ? (NUM_SRC'(1) << grant) : '0;
    assign next_ptr = (int'(grant) == NUM_SRC - 1) ? '0 : grant + GW'(1);

    // First requester at or after rr_ptr, wrapping at NUM_SRC.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_SRC;
            if (!found && s_valid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            count       <= '0;
            tail_flit   <= '0;
            first_word  <= 1'b0;
            o_data_out  <= '0;
            o_dest_out  <= '0;
            o_head_out  <= 1'b0;
            o_tail_out  <= 3'b000;
            o_valid_out <= 1'b0;
`ifdef PKT_SCHED_PKT_COUNT_EN
            o_pkt_count <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant      <= pick;
                        first_word <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept && is_last) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                o_data_out  <= sel_data;
                o_valid_out <= 1'b1;
                o_head_out  <= first_word;
                first_word  <= 1'b0;
                if (first_word) begin
                    o_dest_out <= sel_dest;
                    count      <= sel_len;
                    tail_flit  <= sel_tail;
                end else begin
                    count <= count - LEN_WIDTH'(1);
                end
                // Single-word packets use the live tail flit, not the stale latch.
                o_tail_out <= is_last ? {1'b1, (first_word ? sel_tail : tail_flit)} : 3'b000;
`ifdef PKT_SCHED_PKT_COUNT_EN
                if (is_last) begin
                    o_pkt_count <= o_pkt_count + 16'h0001;
                end
`endif
            end else if (o_ready_in) begin
                o_valid_out <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_packet_scheduler.sv
// ============================================================================
// tb_packet_scheduler
// Directed bench: per-packet expected-word queue checked on every output
// handshake, plus stall-hold and literal checks for the scheduling rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_packet_scheduler;

    localparam int NS = 2;
    localparam int W  = 32;
    localparam int AW = 4;
    localparam int LW = 8;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [AW-1:0] dest;
        logic          head;
        logic [2:0]    tail;
    } word_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS-1:0]     s_valid = '0;
    logic [NS-1:0]     s_ready;
    logic [NS*W-1:0]   s_data = '0;
    logic [NS*AW-1:0]  s_dest = '0;
    logic [NS*LW-1:0]  s_len = '0;
    logic [NS*2-1:0]   s_tail_flit = '0;
    logic [W-1:0]      o_data_out;
    logic [AW-1:0]     o_dest_out;
    logic              o_head_out;
    logic [2:0]        o_tail_out;
    logic              o_valid_out;
    logic              rdy = 1'b1;
`ifdef PKT_SCHED_PKT_COUNT_EN
    logic [15:0]       o_pkt_count;
`endif

    int    checks   = 0;
    int    failures = 0;
    bit    abort    = 1'b0;
    word_t exp_q[$];
    word_t hs_log[$];

    always #5 clk = ~clk;

    packet_scheduler #(
        .NUM_SRC(NS), .WIDTH_IN(W), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_dest(s_dest), .s_len(s_len), .s_tail_flit(s_tail_flit),
        .o_data_out(o_data_out), .o_dest_out(o_dest_out),
        .o_head_out(o_head_out), .o_tail_out(o_tail_out),
        .o_valid_out(o_valid_out),
`ifdef PKT_SCHED_PKT_COUNT_EN
        .o_pkt_count(o_pkt_count),
`endif
        .o_ready_in(rdy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected words of one packet, derived from the packet description.
    task automatic push_pkt(input int len, input int dest, input int tf, input logic [W-1:0] base);
        word_t e;
        for (int k = 0; k <= len; k++) begin
            e.data = base + W'(k);
            e.dest = AW'(dest);
            e.head = (k == 0);
            e.tail = (k == len) ? {1'b1, 2'(tf)} : 3'b000;
            exp_q.push_back(e);
        end
    endtask

    // Compare process: every output handshake against the expected queue.
    initial begin
        word_t cur, prev, e;
        bit    stalled_prev;
        stalled_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {o_data_out, o_dest_out, o_head_out, o_tail_out};
            if (rst) begin
                stalled_prev = 1'b0;
            end else begin
                if (stalled_prev) check("stall_hold", cur, prev);
                if (o_valid_out && !rdy) check("stall_sready", s_ready, '0);
                if (o_valid_out && rdy) begin
                    hs_log.push_back(cur);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word actual=%h required=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_word", cur, e);
                    end
                end
                stalled_prev = o_valid_out && !rdy;
                prev = cur;
            end
        end
    end

    task automatic send(input int src, input int len, input int dest, input int tf,
                        input logic [W-1:0] base, input int gap_k, input int gap_n);
        int k, g, cyc;
        k = 0; g = 0; cyc = 0;
        while (k <= len && !abort && cyc < 300) begin
            @(posedge clk); #1;
            if (k == gap_k && g < gap_n) begin
                s_valid[src] = 1'b0;
                g++;
            end else begin
                s_valid[src] = 1'b1;
                s_data[src*W +: W] = base + W'(k);
                if (k == 0) begin
                    s_dest[src*AW +: AW]     = AW'(dest);
                    s_len[src*LW +: LW]      = LW'(len);
                    s_tail_flit[src*2 +: 2]  = 2'(tf);
                end else begin
                    s_dest[src*AW +: AW]     = AW'($urandom);
                    s_len[src*LW +: LW]      = LW'($urandom);
                    s_tail_flit[src*2 +: 2]  = 2'($urandom);
                end
            end
            @(negedge clk);
            if (s_valid[src] && s_ready[src]) k++;
            cyc++;
        end
        if (cyc >= 300) check("send_timeout", 64'(k), 64'(len + 1));
        @(posedge clk); #1;
        s_valid[src] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_valid_out) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_valid", o_valid_out, 1'b0);
        check("rst_sready", s_ready, '0);
        check("rst_head_tail", {o_head_out, o_tail_out}, 4'h0);
        check("rst_data_dest", {o_data_out, o_dest_out}, '0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        hs_log.delete();
    endtask

    initial begin
        logic [W-1:0] stall_data;
        apply_reset();

        // Single-word packet: head and tail together
        push_pkt(0, 5, 2, 32'h0001_0000);
        send(0, 0, 5, 2, 32'h0001_0000, -1, 0);
        wait_drain("t034_drain");
        check("t034_head", hs_log[0].head, 1'b1);
        check("t034_tail", hs_log[0].tail, 3'b110);

        // Two requesters from reset, two rounds: src0 then src1 each time
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            push_pkt(2, 3, 1, 32'h0002_0000 + 32'(r << 8));
            push_pkt(2, 9, 3, 32'h0102_0000 + 32'(r << 8));
            fork
                send(0, 2, 3, 1, 32'h0002_0000 + 32'(r << 8), -1, 0);
                send(1, 2, 9, 3, 32'h0102_0000 + 32'(r << 8), -1, 0);
            join
            wait_drain("t035_drain");
        end
        check("t035_w2", hs_log[2].data, 32'h0002_0002);
        check("t035_w3", hs_log[3].data, 32'h0102_0000);
        check("t035_w6", hs_log[6].data, 32'h0002_0100);
`ifdef PKT_SCHED_PKT_COUNT_EN
        check("t039_pkt_count", o_pkt_count, 16'd4);
`endif

        // Downstream stall of 5 cycles on word 2 of a 4-word packet
        apply_reset();
        push_pkt(3, 7, 0, 32'h0003_0000);
        fork
            send(0, 3, 7, 0, 32'h0003_0000, -1, 0);
            begin
                int n;
                n = 0;
                while (!(o_valid_out && !o_head_out) && n < 100) begin
                    @(posedge clk); #1;
                    n++;
                end
                rdy = 1'b0;
                stall_data = o_data_out;
                repeat (5) @(posedge clk);
                #1;
                check("t036_stall_start", stall_data, 32'h0003_0001);
                check("t036_stall_end", o_data_out, 32'h0003_0001);
                rdy = 1'b1;
            end
        join
        wait_drain("t036_drain");

        // Granted src0 pauses mid-packet; src1 must wait for src0 tail
        apply_reset();
        push_pkt(3, 4, 1, 32'h0004_0000);
        push_pkt(1, 6, 2, 32'h0104_0000);
        fork
            send(0, 3, 4, 1, 32'h0004_0000, 1, 4);
            send(1, 1, 6, 2, 32'h0104_0000, -1, 0);
        join
        wait_drain("t037_drain");
        check("t037_src0_tail", {hs_log[3].data, hs_log[3].tail}, {32'h0004_0003, 3'b101});

        // Reset mid-packet after moving rr_ptr to 1
        apply_reset();
        push_pkt(0, 1, 0, 32'h0005_0000);
        send(0, 0, 1, 0, 32'h0005_0000, -1, 0);
        wait_drain("t038_pre_drain");
        push_pkt(3, 2, 0, 32'h0006_0000);
        fork
            send(0, 3, 2, 0, 32'h0006_0000, -1, 0);
            begin
                int n;
                n = 0;
                while (!(o_valid_out && !o_head_out) && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                #2;
                rst = 1'b1;
                #1;
                check("t038_async_valid", o_valid_out, 1'b0);
                check("t038_async_sready", s_ready, '0);
                abort = 1'b1;
                exp_q.delete();
                @(negedge clk);
                rst = 1'b0;
            end
        join
        abort = 1'b0;
        hs_log.delete();
        push_pkt(1, 8, 1, 32'h0007_0000);
        push_pkt(1, 9, 2, 32'h0107_0000);
        fork
            send(0, 1, 8, 1, 32'h0007_0000, -1, 0);
            send(1, 1, 9, 2, 32'h0107_0000, -1, 0);
        join
        wait_drain("t038_drain");
        check("t038_first_after_rst", hs_log[0].data, 32'h0007_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
